// File: rtl/channel_resp_split_pkg.sv
// Shared types for the channel response split path: the AMI response
// record carried on every response interface and the default tag depth.
package channel_resp_split_pkg;

  localparam int AMI_DATA_W = 64;
  localparam int AMI_SIZE_W = 6;

  // log2 of the number of reads that may be outstanding on one channel
  localparam int CHANNEL_RESP_TAG_DEPTH = 5;

  typedef struct packed {
    logic                  valid;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIResp;

endpackage

// File: rtl/channel_resp_split_resp_port_buffer.sv
// Small registered FIFO of AMI responses that sits in front of one app port.
// The head is presented straight from the storage registers; when the buffer
// is empty the head reads as all zeros so the port sees valid=0 and no data.
import channel_resp_split_pkg::*;

module channel_resp_split_resp_port_buffer #(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   enq,
  input  AMIResp enq_data,
  input  logic   deq,
  output logic   full,
  output logic   empty,
  output AMIResp head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  AMIResp      mem [DEPTH];
  logic        do_enq;
  logic        do_deq;

  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_deq = deq && !empty;
  // a full buffer may still take a new entry when its head leaves this cycle
  assign do_enq = enq && (!full || do_deq);
  assign head   = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr_reg[AW-1:0]] <= enq_data;
  end

  // read/write pointers, wrapping through the extra MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/channel_resp_split.sv
// Return path of a per-app memory channel. Every read the merge stage issues
// records its source port in a tag FIFO; in-order channel responses are then
// steered to the port at the head of that FIFO through per-port buffers.
// Optional orphan/discard error reporting is built when RESP_SPLIT_ERR_EN is
// defined; otherwise err_orphan and err_count are tied to zero.
import channel_resp_split_pkg::*;

module channel_resp_split #(
  parameter  int NUM_PORTS      = 4,
  parameter  int LOG_TAG_DEPTH  = CHANNEL_RESP_TAG_DEPTH,
  parameter  int PORT_BUF_DEPTH = 2,
  localparam int PORT_BITS      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_issue_valid,
  input  logic [PORT_BITS-1:0]  rd_issue_port,
  output logic                  rd_issue_ready,
  input  AMIResp                ami_mem_resp_in,
  output logic                  ami_mem_resp_grant_out,
  output AMIResp                ami_mem_resp_out [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]  ami_mem_resp_grant_in,
  output logic                  err_orphan,
  output logic [15:0]           err_count
);

  localparam int TAG_DEPTH = 1 << LOG_TAG_DEPTH;

  logic [LOG_TAG_DEPTH:0] tag_wr_ptr_reg;
  logic [LOG_TAG_DEPTH:0] tag_rd_ptr_reg;
  logic [PORT_BITS-1:0]   tag_mem [TAG_DEPTH];
  logic [PORT_BITS-1:0]   head_tag;
  logic                   tag_empty;
  logic                   tag_full;
  logic                   tag_push;
  logic                   accept;
  logic [NUM_PORTS-1:0]   port_sel;
  logic [NUM_PORTS-1:0]   pbuf_full;
  logic [NUM_PORTS-1:0]   pbuf_empty;
  logic                   head_in_range;
  logic                   head_full;
  AMIResp                 resp_wr;

  assign tag_empty = (tag_wr_ptr_reg == tag_rd_ptr_reg);
  assign tag_full  = (tag_wr_ptr_reg[LOG_TAG_DEPTH] != tag_rd_ptr_reg[LOG_TAG_DEPTH]) &&
                     (tag_wr_ptr_reg[LOG_TAG_DEPTH-1:0] == tag_rd_ptr_reg[LOG_TAG_DEPTH-1:0]);
  assign head_tag  = tag_mem[tag_rd_ptr_reg[LOG_TAG_DEPTH-1:0]];

  // occupancy only: a response popping a tag this cycle does not free a slot early
  assign rd_issue_ready = rst_n && !tag_full;
  assign tag_push       = rd_issue_valid && rd_issue_ready;

  // an out-of-range head tag matches no port and is accepted and dropped
  assign head_in_range = |port_sel;
  assign head_full     = |(port_sel & pbuf_full);
  assign accept        = ami_mem_resp_in.valid && !tag_empty && !head_full;
  assign ami_mem_resp_grant_out = accept;

  assign resp_wr = '{valid: 1'b1, data: ami_mem_resp_in.data, size: ami_mem_resp_in.size};

  // tag storage; a tag written this cycle reaches the head next cycle at the earliest
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_ptr_reg[LOG_TAG_DEPTH-1:0]] <= rd_issue_port;
  end

  // tag FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
    end else begin
      if (tag_push) tag_wr_ptr_reg <= tag_wr_ptr_reg + 1'b1;
      if (accept)   tag_rd_ptr_reg <= tag_rd_ptr_reg + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_sel[gi] = (head_tag == PORT_BITS'(gi));

    channel_resp_split_resp_port_buffer #(
      .DEPTH (PORT_BUF_DEPTH)
    ) u_pbuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .enq      (accept && port_sel[gi]),
      .enq_data (resp_wr),
      .deq      (ami_mem_resp_grant_in[gi]),
      .full     (pbuf_full[gi]),
      .empty    (pbuf_empty[gi]),
      .head     (ami_mem_resp_out[gi])
    );
  end

`ifdef RESP_SPLIT_ERR_EN
  logic        err_event;
  logic        err_orphan_reg;
  logic [15:0] err_count_reg;

  assign err_event = (ami_mem_resp_in.valid && tag_empty) || (accept && !head_in_range);

  // sticky orphan flag and saturating event counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan_reg <= 1'b0;
      err_count_reg  <= '0;
    end else if (err_event) begin
      err_orphan_reg <= 1'b1;
      if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign err_orphan = err_orphan_reg;
  assign err_count  = err_count_reg;
`else
  assign err_orphan = 1'b0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_channel_resp_split.sv
// Directed self-checking bench for channel_resp_split (NUM_PORTS=4, 32 tags,
// 2-entry port buffers). Inputs change 1 ns after the rising edge and
// outputs are sampled 3 ns after it, well away from the clock edge.
import channel_resp_split_pkg::*;

module tb_channel_resp_split;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd_issue_valid = 1'b0;
  logic [1:0]   rd_issue_port = '0;
  logic         rd_issue_ready;
  AMIResp       resp_in = '0;
  logic         grant_out;
  AMIResp       resp_out [4];
  logic [3:0]   grant_in = 4'hF;
  logic         err_orphan;
  logic [15:0]  err_count;

  int checks = 0;
  int failures = 0;

  channel_resp_split #(
    .NUM_PORTS      (4),
    .LOG_TAG_DEPTH  (5),
    .PORT_BUF_DEPTH (2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rd_issue_valid         (rd_issue_valid),
    .rd_issue_port          (rd_issue_port),
    .rd_issue_ready         (rd_issue_ready),
    .ami_mem_resp_in        (resp_in),
    .ami_mem_resp_grant_out (grant_out),
    .ami_mem_resp_out       (resp_out),
    .ami_mem_resp_grant_in  (grant_in),
    .err_orphan             (err_orphan),
    .err_count              (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_resp(input logic v, input logic [63:0] d);
    resp_in = '{valid: v, data: d, size: 6'd8};
  endtask

  function automatic logic [3:0] valid_vec();
    return {resp_out[3].valid, resp_out[2].valid, resp_out[1].valid, resp_out[0].valid};
  endfunction

  logic [63:0] exp_data [3];
  int          exp_port [3];
  int          ngrant;

  initial begin
    exp_data[0] = 64'hD000_0000_0000_00A0; exp_port[0] = 2;
    exp_data[1] = 64'hD000_0000_0000_00A1; exp_port[1] = 0;
    exp_data[2] = 64'hD000_0000_0000_00A2; exp_port[2] = 3;

    // reset state
    #3;
    check("rst_ready", rd_issue_ready, 0);
    check("rst_valid", valid_vec(), 0);
    check("rst_grant", grant_out, 0);
    check("rst_err", {err_orphan, err_count}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", rd_issue_ready, 1);

    // orphan response with no reads issued
    set_resp(1'b1, 64'h0BAD);
    #2;
    check("orphan_grant", grant_out, 0);
    tick();
    set_resp(1'b0, 0);
`ifdef RESP_SPLIT_ERR_EN
    check("orphan_flag", err_orphan, 1);
    check("orphan_count", err_count, 1);
`else
    check("orphan_flag", err_orphan, 0);
    check("orphan_count", err_count, 0);
`endif

    // basic steering: ports 2,0,3
    rd_issue_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_issue_port = 2'(exp_port[k]);
      tick();
    end
    rd_issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_resp(1'b1, exp_data[k]);
      #2;
      check($sformatf("steer_grant%0d", k), grant_out, 1);
      tick();
      check($sformatf("steer_valid%0d", k), resp_out[exp_port[k]].valid, 1);
      check($sformatf("steer_data%0d", k), resp_out[exp_port[k]].data, exp_data[k]);
    end
    set_resp(1'b0, 0);
    tick();
    check("steer_drained", valid_vec(), 0);

    // fill all 32 tags without responses
    rd_issue_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_issue_port = 2'(i % 4);
      tick();
    end
    rd_issue_valid = 1'b0;
    check("full_ready", rd_issue_ready, 0);
    set_resp(1'b1, 64'h55);
    #2;
    check("full_grant", grant_out, 1);
    tick();
    check("ready_back", rd_issue_ready, 1);
    ngrant = 0;
    for (int i = 0; i < 31; i++) begin
      #2;
      if (grant_out) ngrant++;
      tick();
    end
    set_resp(1'b0, 0);
    check("drain_count", ngrant, 31);
    tick();
    check("drain_empty", valid_vec(), 0);

    // head-of-line blocking on port 1
    grant_in = 4'b1101;
    rd_issue_valid = 1'b1;
    rd_issue_port = 2'd1; tick(); tick(); tick();
    rd_issue_port = 2'd0; tick();
    rd_issue_valid = 1'b0;
    set_resp(1'b1, 64'hE0); #2; check("hol_grant0", grant_out, 1); tick();
    set_resp(1'b1, 64'hE1); #2; check("hol_grant1", grant_out, 1); tick();
    set_resp(1'b1, 64'hE2);
    #2;
    check("hol_stall", grant_out, 0);
    tick();
    #2;
    check("hol_stall2", grant_out, 0);
    check("hol_port0_idle", resp_out[0].valid, 0);
    check("hol_port1_head", resp_out[1].data, 64'hE0);
    tick();
    grant_in = 4'hF;
    #2;
    check("hol_release_grant", grant_out, 0);
    tick();
    #2;
    check("hol_e2_grant", grant_out, 1);
    check("hol_port1_e1", resp_out[1].data, 64'hE1);
    tick();
    set_resp(1'b1, 64'hE3);
    #2;
    check("hol_e3_grant", grant_out, 1);
    check("hol_port1_e2", resp_out[1].data, 64'hE2);
    tick();
    set_resp(1'b0, 0);
    check("hol_port0_e3", resp_out[0].data, 64'hE3);
    check("hol_valid_vec", valid_vec(), 4'b0001);
    tick();

    // same-cycle issue and response: no bypass
    rd_issue_valid = 1'b1;
    rd_issue_port  = 2'd3;
    set_resp(1'b1, 64'hF3);
    #2;
    check("same_cycle_grant", grant_out, 0);
    tick();
    rd_issue_valid = 1'b0;
    #2;
    check("next_cycle_grant", grant_out, 1);
    tick();
    set_resp(1'b0, 0);
    check("same_cycle_data", resp_out[3].data, 64'hF3);
    tick();

    // reset in the middle of traffic
    grant_in = 4'b1011;
    rd_issue_valid = 1'b1;
    rd_issue_port  = 2'd2;
    tick(); tick();
    rd_issue_valid = 1'b0;
    set_resp(1'b1, 64'hC0);
    tick();
    check("mid_valid_before", resp_out[2].valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_vec(), 0);
    check("mid_rst_data", resp_out[2].data, 0);
    check("mid_rst_ready", rd_issue_ready, 0);
    check("mid_rst_grant", grant_out, 0);
    check("mid_rst_err", {err_orphan, err_count}, 0);
    set_resp(1'b0, 0);
    grant_in = 4'hF;
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", rd_issue_ready, 1);
    set_resp(1'b1, 64'hC1);
    #2;
    check("post_rst_no_tag", grant_out, 0);
    tick();
    set_resp(1'b0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
